// File: rtl/data_memory.sv
// rtl/data_memory.sv - RV32I byte-addressable data memory, sync byte-lane writes, comb extended reads
// Optional macro DMEM_ALIGN_CHECK_EN adds misaligned/misalign_err and blocks misaligned accesses.
module data_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic                  misaligned,
  output logic                  misalign_err,
`endif
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_BITS-1:0]  word_idx;
  logic [1:0]            lane;
  logic [3:0]            byte_we;
  logic [DATA_WIDTH-1:0] wdata_lanes;
  logic [DATA_WIDTH-1:0] rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic                  misalign_now;
  logic                  unused_addr_hi;

  assign word_idx = addr[ADDR_BITS+1:2];
  assign lane     = addr[1:0];

  // High address bits only alias onto the array; they are deliberately dropped.
  assign unused_addr_hi = ^addr[DATA_WIDTH-1:ADDR_BITS+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_err_q;
  logic misalign_err_d;

  assign misalign_now = (mem_read | mem_write) &
                        ((((funct3 == 3'b001) || (funct3 == 3'b101)) & addr[0]) |
                         ((funct3 == 3'b010) & (addr[1:0] != 2'b00)));
  assign misaligned   = misalign_now;
  assign misalign_err = misalign_err_q;

  // Sticky error: once any edge sees a misaligned access it holds until reset.
  always_comb begin
    misalign_err_d = misalign_err_q | misalign_now;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err_q <= 1'b0;
    else        misalign_err_q <= misalign_err_d;
  end
`else
  assign misalign_now = 1'b0;
`endif

  // Decode store size into byte enables and replicate data onto every lane it may land in.
  always_comb begin
    byte_we     = 4'b0000;
    wdata_lanes = '0;
    if (mem_write && !misalign_now) begin
      case (funct3)
        3'b000: begin
          byte_we     = 4'b0001 << lane;
          wdata_lanes = {4{write_data[7:0]}};
        end
        3'b001: begin
          byte_we     = addr[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{write_data[15:0]}};
        end
        3'b010: begin
          byte_we     = 4'b1111;
          wdata_lanes = write_data;
        end
        default: begin
          byte_we     = 4'b0000;
          wdata_lanes = '0;
        end
      endcase
    end
  end

  // Storage array: async clear of every word, byte-lane writes on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (byte_we[b]) mem_q[word_idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
      end
    end
  end

  // Combinational load path: select lane, then sign or zero extend.
  always_comb begin
    rword     = mem_q[word_idx];
    rbyte     = rword[{lane, 3'b000} +: 8];
    rhalf     = rword[{addr[1], 4'b0000} +: 16];
    read_data = '0;
    if (mem_read && !misalign_now) begin
      case (funct3)
        3'b000:  read_data = {{24{rbyte[7]}}, rbyte};
        3'b001:  read_data = {{16{rhalf[15]}}, rhalf};
        3'b010:  read_data = rword;
        3'b100:  read_data = {24'h000000, rbyte};
        3'b101:  read_data = {16'h0000, rhalf};
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misaligned;
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_memory #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
`ifdef DMEM_ALIGN_CHECK_EN
    .misaligned (misaligned),
    .misalign_err (misalign_err),
`endif
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    funct3     = f3;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = f3;
    addr     = a;
    #1;
    check(tag, read_data, exp);
    mem_read = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    write_data = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    do_load("reset_lw0", 3'b010, 32'h0000_0000, 32'h0000_0000);

    // Async reset pulse in mid-cycle clears a stored word
    do_store(3'b010, 32'h10, 32'hDEAD_BEEF);
    do_load("lw_deadbeef", 3'b010, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h10;
    #2 rst_n = 1'b0;
    #1 check("reset_async_read", read_data, 32'h0000_0000);
    #1 rst_n = 1'b1;
    mem_read = 1'b0;
    do_load("after_reset_lw", 3'b010, 32'h10, 32'h0000_0000);

    // Reset held across an edge with a store pending: store lost
    @(negedge clk);
    mem_write  = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h10;
    write_data = 32'h1234_5678;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
    rst_n      = 1'b1;
    do_load("store_during_reset", 3'b010, 32'h10, 32'h0000_0000);
    do_store(3'b010, 32'h10, 32'h0BAD_F00D);
    do_load("writes_resume", 3'b010, 32'h10, 32'h0BAD_F00D);

    // Byte stores and sign/zero extension
    do_store(3'b010, 32'h20, 32'h1122_3344);
    do_store(3'b000, 32'h22, 32'h0000_00F0);
    do_load("lw_0x20", 3'b010, 32'h20, 32'h11F0_3344);
    do_load("lb_0x22", 3'b000, 32'h22, 32'hFFFF_FFF0);
    do_load("lbu_0x22", 3'b100, 32'h22, 32'h0000_00F0);
    do_load("lb_0x21_pos", 3'b000, 32'h21, 32'h0000_0033);
    do_load("lh_0x20", 3'b001, 32'h20, 32'h0000_3344);
    do_load("lhu_0x22", 3'b101, 32'h22, 32'h0000_11F0);

    // Halfword store into upper half
    do_store(3'b001, 32'h26, 32'h0000_ABCD);
    do_load("lh_0x26", 3'b001, 32'h26, 32'hFFFF_ABCD);
    do_load("lhu_0x26", 3'b101, 32'h26, 32'h0000_ABCD);
    do_load("lw_0x24", 3'b010, 32'h24, 32'hABCD_0000);

`ifndef DMEM_ALIGN_CHECK_EN
    // Truncating lane rules for unaligned accesses
    do_store(3'b001, 32'h29, 32'hFFFF_1234);
    do_load("sh_addr0_ignored", 3'b010, 32'h28, 32'h0000_1234);
    do_store(3'b010, 32'h2F, 32'h8765_4321);
    do_load("sw_low_ignored", 3'b010, 32'h2C, 32'h8765_4321);
    do_load("lw_unaligned_trunc", 3'b010, 32'h2E, 32'h8765_4321);
`endif

    // Aliasing and wrap
    do_store(3'b010, 32'h400, 32'hCAFE_F00D);
    do_load("alias_0x000", 3'b010, 32'h000, 32'hCAFE_F00D);
    do_store(3'b010, 32'h3FC, 32'hA5A5_A5A5);
    do_load("alias_0x7FC", 3'b010, 32'h7FC, 32'hA5A5_A5A5);
    do_load("no_spill_0x000", 3'b010, 32'h000, 32'hCAFE_F00D);
    do_load("alias_hi_bits", 3'b010, 32'hFFFF_F000, 32'hCAFE_F00D);

    // Read during write
    @(negedge clk);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h30;
    write_data = 32'h55AA_55AA;
    #1 check("rdw_before", read_data, 32'h0000_0000);
    @(posedge clk);
    #1 check("rdw_after", read_data, 32'h55AA_55AA);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    #1 check("mem_read_low", read_data, 32'h0000_0000);

    // Illegal store and load codes
    do_store(3'b011, 32'h30, 32'hFFFF_FFFF);
    do_store(3'b100, 32'h30, 32'hFFFF_FFFF);
    do_load("illegal_store_kept", 3'b010, 32'h30, 32'h55AA_55AA);
    do_load("illegal_load_011", 3'b011, 32'h30, 32'h0000_0000);
    do_load("illegal_load_110", 3'b110, 32'h30, 32'h0000_0000);

`ifdef DMEM_ALIGN_CHECK_EN
    do_store(3'b010, 32'h40, 32'hAAAA_BBBB);
    check("align_err_init", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    mem_write  = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h41;
    write_data = 32'h1234_5678;
    #1 check("misaligned_flag", {31'h0, misaligned}, 32'h1);
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("misalign_err_set", {31'h0, misalign_err}, 32'h1);
    do_load("misaligned_store_blocked", 3'b010, 32'h40, 32'hAAAA_BBBB);
    check("misalign_err_sticky", {31'h0, misalign_err}, 32'h1);
    do_load("misaligned_load_zero", 3'b001, 32'h41, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("misalign_err_reset", {31'h0, misalign_err}, 32'h0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
